// File: rtl/square_pkg.sv
// rtl/square_pkg.sv - shared constants and types for the rotating-square driver
package square_pkg;

    localparam logic [7:0] SEG_UPPER  = 8'h9C;
    localparam logic [7:0] SEG_LOWER  = 8'hA3;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam int         NUM_DIGITS = 8;
    localparam int         NUM_POS    = 16;

    typedef logic [3:0] pos_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable-gated prescaler producing a one-cycle animation tick
module tick_gen #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] presc_q;
    logic [W-1:0] presc_d;

    // Disabling holds the count so a resumed animation keeps its phase.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (en) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/square_circuit.sv
// rtl/square_circuit.sv - single square circling an 8-digit seven-segment display
module square_circuit
    import square_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cw,
    output logic [7:0] seg,
    output logic [7:0] digit
);

    logic tick;
    pos_t pos_q;
    pos_t pos_d;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    always_comb begin
        pos_d = pos_q;
        if (tick) begin
            pos_d = cw ? pos_q + 4'd1 : pos_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Positions 0..7 walk the top halves leftmost-first; 8..15 come back along the bottom.
    always_comb begin
        digit = SEG_OFF;
        if (!pos_q[3]) begin
            seg               = SEG_UPPER;
            digit[~pos_q[2:0]] = 1'b0;
        end else begin
            seg               = SEG_LOWER;
            digit[pos_q[2:0]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_square_circuit.sv
// tb/tb_square_circuit.sv - scoreboard bench for square_circuit with TICK_DIV=2
module tb_square_circuit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cw;
    logic [7:0] seg;
    logic [7:0] digit;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] sb_q[$];
    int          m_presc;
    int          m_pos;

    logic [7:0] up_digit [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] lo_digit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    square_circuit #(
        .TICK_DIV (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cw    (cw),
        .seg   (seg),
        .digit (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expected_out(input int p);
        if (p < 8) return {8'h9C, up_digit[p]};
        return {8'hA3, lo_digit[p - 8]};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp_seg, input logic [7:0] exp_digit);
        vectors++;
        assert ((seg === exp_seg) && (digit === exp_digit)) else begin
            miscompares++;
            $error("FAIL %s: observed seg=%h digit=%h, expected seg=%h digit=%h",
                   tag, seg, digit, exp_seg, exp_digit);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic c);
        logic [15:0] exp;
        @(negedge clk);
        rst_n = r;
        en    = e;
        cw    = c;
        @(posedge clk);
        if (r) begin
            m_presc = 0;
            m_pos   = 0;
        end else if (e) begin
            if (m_presc == 1) begin
                m_presc = 0;
                m_pos   = c ? (m_pos + 1) % 16 : (m_pos + 15) % 16;
            end else begin
                m_presc = m_presc + 1;
            end
        end
        sb_q.push_back(expected_out(m_pos));
        #1;
        exp = sb_q.pop_front();
        check(tag, exp[15:8], exp[7:0]);
    endtask

    initial begin
        rst_n   = 1'b1;
        en      = 1'b1;
        cw      = 1'b1;
        m_presc = 0;
        m_pos   = 0;

        for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b1, 1'b1);
        check("reset_value", 8'h9C, 8'h7F);

        for (int i = 0; i < 32; i++) step("forward_walk", 1'b0, 1'b1, 1'b1);
        check("forward_wrap", 8'h9C, 8'h7F);

        // presc is 1 after these; freezing here makes resume step on the first enabled edge
        for (int i = 0; i < 5; i++) step("pre_freeze", 1'b0, 1'b1, 1'b1);
        check("pre_freeze_pos2", 8'h9C, 8'hDF);
        for (int i = 0; i < 20; i++) step("freeze", 1'b0, 1'b0, 1'b1);
        check("freeze_hold", 8'h9C, 8'hDF);
        step("resume", 1'b0, 1'b1, 1'b1);
        check("resume_presc_kept", 8'h9C, 8'hEF);
        for (int i = 0; i < 3; i++) step("post_resume", 1'b0, 1'b1, 1'b1);

        step("dir_reset", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step("dir_fwd", 1'b0, 1'b1, 1'b1);
        check("dir_pos3", 8'h9C, 8'hEF);
        for (int i = 0; i < 2; i++) step("dir_back", 1'b0, 1'b1, 1'b0);
        check("dir_pos2", 8'h9C, 8'hDF);

        step("rev_reset", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step("rev_wrap", 1'b0, 1'b1, 1'b0);
        check("rev_pos15", 8'hA3, 8'h7F);
        for (int i = 0; i < 2; i++) step("rev_step", 1'b0, 1'b1, 1'b0);
        check("rev_pos14", 8'hA3, 8'hBF);

        step("mid_reset_init", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step("to_pos10", 1'b0, 1'b1, 1'b1);
        check("at_pos10", 8'hA3, 8'hFB);
        for (int i = 0; i < 3; i++) step("mid_reset", 1'b1, 1'b1, 1'b1);
        check("mid_reset_value", 8'h9C, 8'h7F);
        for (int i = 0; i < 4; i++) step("after_release", 1'b0, 1'b1, 1'b1);
        check("after_release_pos2", 8'h9C, 8'hDF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/square_circuit.md
Name: square_circuit

Overview:
- Rotating-square animation driver for an 8-digit, multiplexed-anode seven-segment display.
- A single lit square steps around the display: across the top halves of the digits left to right, then back along the bottom halves right to left.
- Direction is selected by `cw`; motion is gated by `en`.
- Sits directly under the board top level, driving the `seg` and `digit` pins.

Parameters:
- TICK_DIV, default 25_000_000, clock cycles per animation step (must be ≥1; benches use 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset. The port keeps the codebase name `rst_n`, but a 1 sampled on a rising `clk` edge resets the block.
- en  input  1  1 = animate, 0 = freeze the current position.
- cw  input  1  1 = step forward (clockwise), 0 = step backward.
- seg  output  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.
- digit  output  8  digit-enable, active-low one-hot; digit[7] is the leftmost digit.

Behaviour:

State:
- `presc`: counter, ceil(log2(TICK_DIV)) bits.
- `pos`: 4-bit position register, 0..15.

Reset (`rst_n`=1 at a clock edge):
- `presc` ← 0, `pos` ← 0.
- Takes priority over `en` and `cw`.
- Resetting mid-animation returns to `pos`=0 on the next edge.

Prescaler:
- When `en`=1: `presc` increments each cycle. At TICK_DIV-1 it wraps to 0 and asserts an internal one-cycle `tick` in that same cycle.
- When `en`=0: `presc` holds its value (it is not cleared) and `tick`=0.

Position update:
- On `tick`: `pos` ← `pos`+1 mod 16 if `cw`=1, else `pos`-1 mod 16. Wrap-around: 15→0 (cw=1), 0→15 (cw=0).
- `cw` is sampled only on the tick edge, so a change to `cw` between ticks takes effect at the next tick.
- `en` falling between ticks freezes `pos`. Rising `en` resumes counting from the held `presc`.

Output decode (combinational from `pos`, no extra latency):
- `pos` 0..7: upper square on digit index 7-`pos`. `seg`=8'h9C (a,b,f,g on); `digit` = one-hot-low with bit (7-`pos`) = 0.
- `pos` 8..15: lower square on digit index `pos`-8. `seg`=8'hA3 (c,d,e,g on); `digit` bit (`pos`-8) = 0.
- Exactly one `digit` bit is low at all times. The decimal point (`seg[7]`) is always 1.

Reset output values:
- `seg`=8'h9C, `digit`=8'h7F.

Step latency:
- With TICK_DIV=N and `en` held at 1 from `presc`=0, the first step is visible after the N-th rising edge, then every N cycles.

Decomposition:
- Shared package `square_pkg`:
  - constants SEG_UPPER=8'h9C, SEG_LOWER=8'hA3, SEG_OFF=8'hFF, NUM_DIGITS=8, NUM_POS=16;
  - typedef `pos_t` = logic [3:0].
- One natural sub-module, `tick_gen` (parameter DIV; ports `clk`, `rst_n`, `en`, `tick`), holding the prescaler.
- The position counter and decoder stay in square_circuit.

Test Plan (TICK_DIV=2, 10 ns clock):
- Reset: hold `rst_n`=1 for 2 edges with en=1 → `seg`=8'h9C, `digit`=8'h7F, and they stay there while reset is held.
- Forward walk: release reset, en=1, cw=1 → `digit` sequence 7F,BF,DF,EF,F7,FB,FD,FE with `seg`=9C, then FE,FD,FB,F7,EF,DF,BF,7F with `seg`=A3; one step per 2 cycles; after 32 cycles `pos` wraps back to 0 (7F/9C).
- Reverse and wrap: from reset, en=1, cw=0 → first step gives `digit`=8'h7F, `seg`=8'hA3 (`pos` 15), then 8'hBF/A3.
- Freeze: en=0 for 20 cycles mid-walk → `seg`/`digit` constant. Re-enable → the next step arrives no later than TICK_DIV cycles later, with `presc` resumed rather than cleared.
- Direction change: switch cw 1→0 after 3 steps (`pos`=3, `digit`=EF) → the next step returns to `pos`=2 (`digit`=DF, `seg`=9C).
- Reset mid-operation: assert `rst_n`=1 at `pos`=10 → outputs are 9C/7F on the next edge and remain so until release.
